// File: rtl/mc97_ring_gen_pkg.sv
// ---------------------------------------------------------------------------
// mc97_ring_gen_pkg
//   Shared definitions for the MC97 ring-tone generator: codec sample rate,
//   FSM state encoding and a small constant helper used to size counters.
// ---------------------------------------------------------------------------
package mc97_ring_gen_pkg;

    localparam int MC97_FS_HZ = 8000;
    localparam int PCM_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } ring_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mc97_ring_gen.sv
// ---------------------------------------------------------------------------
// mc97_ring_gen
//   Transmit-side ring-tone generator. Produces 16-bit signed PCM samples of a
//   cadenced ring signal (ON burst / OFF gap). One sample is advanced per
//   pcm_stb pulse; all outputs are registered and update on the edge that ends
//   the pcm_stb cycle.
//
//   Build option: define MC97_RING_GEN_TRI_EN for a triangle wave during ON;
//   otherwise a square wave is produced and no multiplier exists.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   ring_en      in   ringing request, sampled on pcm_stb
//   freq_inc     in   phase increment per sample, sampled on pcm_stb
//   pcm_stb      in   1-cycle pulse: advance one sample
//   pcm_data     out  current sample, signed two's complement
//   ring_active  out  high while in a burst
//   burst_stb    out  1-cycle pulse on each entry into a burst
// ---------------------------------------------------------------------------
module mc97_ring_gen
    import mc97_ring_gen_pkg::*;
#(
    parameter int PHASE_W     = 16,
    parameter int AMPL        = 16384,
    parameter int ON_SAMPLES  = 16000,
    parameter int OFF_SAMPLES = 32000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ring_en,
    input  logic [PHASE_W-1:0] freq_inc,
    input  logic               pcm_stb,
    output logic [15:0]        pcm_data,
    output logic               ring_active,
    output logic               burst_stb
);

    localparam int CNT_W = $clog2(max_int(ON_SAMPLES, OFF_SAMPLES) + 1);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_SAMPLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_SAMPLES - 1);

`ifdef MC97_RING_GEN_TRI_EN
    localparam int PROD_W = PHASE_W - 1 + PCM_W;
    localparam logic signed [PHASE_W+1:0] AMPL_T = (PHASE_W + 2)'(AMPL);

    // Fold the phase into a rising ramp 0..2^(PHASE_W-1)-1 and back down,
    // scale to 0..~2*AMPL, then shift down by AMPL to centre on zero.
    function automatic logic signed [PCM_W-1:0] wave_f(input logic [PHASE_W-1:0] ph);
        logic [PHASE_W-2:0]         f;
        logic [PROD_W-1:0]          prod;
        logic [PHASE_W:0]           scaled;
        logic signed [PHASE_W+1:0]  diff;
        f      = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
        prod   = PROD_W'(f) * PROD_W'(AMPL);
        scaled = (PHASE_W + 1)'(prod >> (PHASE_W - 2));
        diff   = $signed({1'b0, scaled}) - AMPL_T;
        return PCM_W'(diff);
    endfunction
`else
    localparam logic signed [PCM_W-1:0] AMPL_S = PCM_W'(AMPL);

    function automatic logic signed [PCM_W-1:0] wave_f(input logic msb);
        return msb ? -AMPL_S : AMPL_S;
    endfunction
`endif

    ring_state_e              state_q, state_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [PCM_W-1:0]  pcm_data_q, pcm_data_d;
    logic                     burst_stb_q, burst_stb_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        pcm_data_d  = pcm_data_q;
        burst_stb_d = 1'b0;

        if (pcm_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (ring_en) begin
                        state_d     = ST_ON;
                        phase_d     = '0;
                        cnt_d       = ON_LOAD;
                        burst_stb_d = 1'b1;
                    end
                end
                ST_ON: begin
                    if (!ring_en) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = ST_OFF;
                        cnt_d   = OFF_LOAD;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        phase_d = phase_q + freq_inc;
                    end
                end
                ST_OFF: begin
                    if (!ring_en) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d     = ST_ON;
                        phase_d     = '0;
                        cnt_d       = ON_LOAD;
                        burst_stb_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // The sample presented is the one for the state/phase just entered.
`ifdef MC97_RING_GEN_TRI_EN
            pcm_data_d = (state_d == ST_ON) ? wave_f(phase_d) : '0;
`else
            pcm_data_d = (state_d == ST_ON) ? wave_f(phase_d[PHASE_W-1]) : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            cnt_q       <= '0;
            pcm_data_q  <= '0;
            burst_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            pcm_data_q  <= pcm_data_d;
            burst_stb_q <= burst_stb_d;
        end
    end

    assign pcm_data    = pcm_data_q;
    assign ring_active = (state_q == ST_ON);
    assign burst_stb   = burst_stb_q;

endmodule

// File: tb/tb_mc97_ring_gen.sv
// ---------------------------------------------------------------------------
// tb_mc97_ring_gen
//   Bench for mc97_ring_gen. Two instances share stimulus:
//     A: AMPL=1000,  ON=64, OFF=5  (long bursts, waveform shape)
//     B: AMPL=16384, ON=4,  OFF=3  (short cadence)
//   Honours MC97_RING_GEN_TRI_EN for the expected waveform.
// ---------------------------------------------------------------------------
module tb_mc97_ring_gen;

    localparam int A_AMPL = 1000;
    localparam int A_ON   = 64;
    localparam int A_OFF  = 5;
    localparam int B_AMPL = 16384;
    localparam int B_ON   = 4;
    localparam int B_OFF  = 3;

`ifdef MC97_RING_GEN_TRI_EN
    localparam int A_S0 = -1000, A_S1 = 0, A_S2 = 999, A_S3 = -1;
    localparam int B_W0 = -16384;
    localparam int B_Q0 = -16384, B_Q1 = -8192, B_Q2 = 0, B_Q3 = 8192;
`else
    localparam int A_S0 = 1000, A_S1 = 1000, A_S2 = -1000, A_S3 = -1000;
    localparam int B_W0 = 16384;
    localparam int B_Q0 = 16384, B_Q1 = 16384, B_Q2 = 16384, B_Q3 = 16384;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ring_en = 1'b0;
    logic        pcm_stb = 1'b0;
    logic [15:0] freq_inc = '0;
    logic [15:0] pcm_a, pcm_b;
    logic        act_a, act_b, bst_a, bst_b;

    always #5 clk = ~clk;

    mc97_ring_gen #(.PHASE_W(16), .AMPL(A_AMPL), .ON_SAMPLES(A_ON), .OFF_SAMPLES(A_OFF)) dut_a (
        .clk(clk), .rst(rst), .ring_en(ring_en), .freq_inc(freq_inc), .pcm_stb(pcm_stb),
        .pcm_data(pcm_a), .ring_active(act_a), .burst_stb(bst_a)
    );

    mc97_ring_gen #(.PHASE_W(16), .AMPL(B_AMPL), .ON_SAMPLES(B_ON), .OFF_SAMPLES(B_OFF)) dut_b (
        .clk(clk), .rst(rst), .ring_en(ring_en), .freq_inc(freq_inc), .pcm_stb(pcm_stb),
        .pcm_data(pcm_b), .ring_active(act_b), .burst_stb(bst_b)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: position within the ON+OFF cadence plus a phase.
    int on_n[2]  = '{A_ON, B_ON};
    int off_n[2] = '{A_OFF, B_OFF};
    int amp_n[2] = '{A_AMPL, B_AMPL};
    int m_ring[2];
    int m_pos[2];
    int m_ph[2];
    int m_pcm[2];
    int m_burst[2];

    function automatic int wave(input int a, input int ph);
`ifdef MC97_RING_GEN_TRI_EN
        int f;
        f = (ph < 32768) ? ph : (65535 - ph);
        return (f * a) / 16384 - a;
`else
        return (ph < 32768) ? a : -a;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ring[i] = 0; m_pos[i] = 0; m_ph[i] = 0; m_pcm[i] = 0; m_burst[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit en, input int inc);
        m_burst[i] = 0;
        if (m_ring[i] == 0) begin
            if (en) begin
                m_ring[i] = 1; m_pos[i] = 0; m_ph[i] = 0; m_burst[i] = 1;
            end
        end else if (!en) begin
            m_ring[i] = 0;
        end else begin
            m_pos[i] = m_pos[i] + 1;
            if (m_pos[i] == on_n[i] + off_n[i]) begin
                m_pos[i] = 0; m_ph[i] = 0; m_burst[i] = 1;
            end else if (m_pos[i] < on_n[i]) begin
                m_ph[i] = (m_ph[i] + inc) % 65536;
            end
        end
        m_pcm[i] = (m_ring[i] != 0 && m_pos[i] < on_n[i]) ? wave(amp_n[i], m_ph[i]) : 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("pcm_a", int'($signed(pcm_a)), m_pcm[0]);
        chk("act_a", int'(act_a), (m_ring[0] != 0 && m_pos[0] < on_n[0]) ? 1 : 0);
        chk("bst_a", int'(bst_a), m_burst[0]);
        chk("pcm_b", int'($signed(pcm_b)), m_pcm[1]);
        chk("act_b", int'(act_b), (m_ring[1] != 0 && m_pos[1] < on_n[1]) ? 1 : 0);
        chk("bst_b", int'(bst_b), m_burst[1]);
    endtask

    task automatic step(input bit stb, input bit en, input int inc);
        @(negedge clk);
        pcm_stb  = stb;
        ring_en  = en;
        freq_inc = inc[15:0];
        @(posedge clk);
        #1;
        pcm_stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (stb) model_step(i, en, inc);
            else     m_burst[i] = 0;
        end
        cmp_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        pcm_stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cmp_all();
    endtask

    typedef struct {
        bit stb;
        bit en;
        int inc;
        int pcm;
        bit act;
        bit bst;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int bursts;
        int bq[4];

        tbl[0] = '{1'b1, 1'b1, 16384, A_S0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 16384, A_S0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16384, A_S1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 16384, A_S2, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16384, A_S3, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16384, A_S0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16384, 0,    1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16384, 0,    1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 16384, A_S0, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 0,     A_S0, 1'b1, 1'b0};
        bq = '{B_Q0, B_Q1, B_Q2, B_Q3};

        // Reset state
        do_reset();
        chk("rst_pcm_a", int'(pcm_a), 0);
        chk("rst_act_b", int'(act_b), 0);

        // Idle: free-running strobes with ring_en low
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 16384);
            chk("idle_pcm", int'(pcm_a), 0);
            chk("idle_bst", int'(bst_a | bst_b), 0);
        end

        // Table-driven waveform on instance A
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].stb, tbl[k].en, tbl[k].inc);
            chk($sformatf("tbl%0d_pcm", k), int'($signed(pcm_a)), tbl[k].pcm);
            chk($sformatf("tbl%0d_act", k), int'(act_a), int'(tbl[k].act));
            chk($sformatf("tbl%0d_bst", k), int'(bst_a), int'(tbl[k].bst));
        end

        // Cadence on instance B: 4 on, 3 off, repeating
        do_reset();
        bursts = 0;
        for (int k = 0; k < 21; k++) begin
            step(1'b1, 1'b1, 1000);
            chk("cad_act", int'(act_b), ((k % 7) < 4) ? 1 : 0);
            chk("cad_bst", int'(bst_b), ((k % 7) == 0) ? 1 : 0);
            if ((k % 7) >= 4) chk("cad_off_pcm", int'($signed(pcm_b)), 0);
            if ((k % 7) == 0) chk("cad_ph0", int'($signed(pcm_b)), B_W0);
            if (bst_b) bursts++;
        end
        chk("cad_bursts", bursts, 3);

        // ring_en dropped on the second sample of a burst, then re-raised
        do_reset();
        step(1'b1, 1'b1, 5000);
        step(1'b1, 1'b0, 5000);
        chk("drop_pcm", int'(pcm_a), 0);
        chk("drop_act", int'(act_a), 0);
        step(1'b1, 1'b1, 5000);
        chk("rearm_pcm", int'($signed(pcm_a)), A_S0);
        chk("rearm_bst", int'(bst_a), 1);

        // rst mid-burst without a strobe
        step(1'b1, 1'b1, 5000);
        chk("pre_rst_act", int'(act_a), 1);
        do_reset();
        chk("mid_rst_pcm", int'(pcm_a), 0);
        chk("mid_rst_act", int'(act_a), 0);
        chk("mid_rst_bst", int'(bst_a), 0);

        // Waveform shape on B: freq_inc=8192, then freq_inc=0
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 8192);
            chk($sformatf("shape%0d", k), int'($signed(pcm_b)), bq[k]);
        end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 0);
            chk("inc0", int'($signed(pcm_b)), B_W0);
        end

        // Randomised stimulus against the model
        do_reset();
        begin
            int inc;
            inc = 3000;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(7) == 0) inc = int'($urandom_range(65535));
                step(bit'($urandom_range(1)), ($urandom_range(39) != 0), inc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
